// File: rtl/classifier3_train_ctrl.sv
// classifier3_train_ctrl
//   Sequencing and scoring stage around a 3-output learning layer. Accepts one
//   labelled sample per s_valid/s_ready handshake, pulses the layer's evaluate
//   strobe, waits SETTLE cycles, captures the argmax of the layer outputs,
//   optionally runs LEARN_CYCLES of learn strobes, and presents the result on an
//   r_valid/r_ready handshake. Keeps saturating sample/correct counters.
//
// Optional feature macro: CLASSIFIER3_SKIP_CORRECT_EN
//   defined   : correctly classified samples skip the learn phase
//   undefined : every labelled training sample runs the learn phase
//
// Ports
//   clock, reset_n              : clock, asynchronous active-low reset
//   s_valid/s_ready             : sample handshake
//   s_label[1:0], s_train       : class index (3 = unlabelled), train request
//   layer_valid, layer_learn    : strobes to the layer
//   layer_out[3], expected_out[3]: layer outputs / training targets
//   r_valid/r_ready             : result handshake
//   r_pred[1:0], r_correct      : argmax class, match against label
//   clear_counts                : synchronous counter clear
//   sample_count, correct_count : saturating accuracy counters
module classifier3_train_ctrl #(
    parameter int unsigned   W            = 8,
    parameter int unsigned   SETTLE       = 2,
    parameter int unsigned   LEARN_CYCLES = 1,
    parameter int unsigned   CNT_W        = 16,
    parameter logic [W-1:0]  TARGET_HI    = '1,
    parameter logic [W-1:0]  TARGET_LO    = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [1:0]          s_label,
    input  logic                s_train,
    output logic                layer_valid,
    output logic                layer_learn,
    input  logic [2:0][W-1:0]   layer_out,
    output logic [2:0][W-1:0]   expected_out,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [1:0]          r_pred,
    output logic                r_correct,
    input  logic                clear_counts,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    correct_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_WAIT,
        S_CAPTURE,
        S_LEARN,
        S_RESULT
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] LEARN_LAST  = 16'(LEARN_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_cnt;
    logic [1:0]    r_label;
    logic          r_train;

    logic [1:0]    w_pred;
    logic [W-1:0]  w_best;
    logic          w_correct;
    logic          w_do_learn;

    // Argmax with strict compare so the lower index wins a tie.
    always_comb begin
        w_pred = '0;
        w_best = layer_out[0];
        for (int unsigned i = 1; i < 3; i++) begin
            if (layer_out[i] > w_best) begin
                w_best = layer_out[i];
                w_pred = 2'(i);
            end
        end
    end

    assign w_correct = (r_label != 2'd3) && (w_pred == r_label);

`ifdef CLASSIFIER3_SKIP_CORRECT_EN
    assign w_do_learn = r_train && (r_label != 2'd3) && !w_correct;
`else
    assign w_do_learn = r_train && (r_label != 2'd3);
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; strobes decode straight from the state register
    // so that reset drops them without waiting for a clock edge.
    always_comb begin
        w_next      = r_state;
        s_ready     = 1'b0;
        layer_valid = 1'b0;
        layer_learn = 1'b0;
        r_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) w_next = S_EVAL;
            end
            S_EVAL: begin
                layer_valid = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == SETTLE_LAST) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = w_do_learn ? S_LEARN : S_RESULT;
            end
            S_LEARN: begin
                layer_valid = 1'b1;
                layer_learn = 1'b1;
                if (r_cnt == LEARN_LAST) w_next = S_RESULT;
            end
            S_RESULT: begin
                r_valid = 1'b1;
                if (r_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Dwell counter restarts on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Sample latch, targets, result and counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_label       <= '0;
            r_train       <= 1'b0;
            expected_out  <= {3{TARGET_LO}};
            r_pred        <= '0;
            r_correct     <= 1'b0;
            sample_count  <= '0;
            correct_count <= '0;
        end else begin
            if (r_state == S_IDLE && s_valid) begin
                r_label <= s_label;
                r_train <= s_train;
                for (int unsigned i = 0; i < 3; i++) begin
                    expected_out[i] <= (s_label == 2'(i)) ? TARGET_HI : TARGET_LO;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_pred    <= w_pred;
                r_correct <= w_correct;
            end
            if (clear_counts) begin
                sample_count  <= '0;
                correct_count <= '0;
            end else if (r_state == S_CAPTURE) begin
                if (sample_count != '1) sample_count <= sample_count + 1'b1;
                if (w_correct && correct_count != '1) correct_count <= correct_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_classifier3_train_ctrl.sv
module tb_classifier3_train_ctrl;

    localparam int unsigned S  = 2;
    localparam int unsigned L  = 1;
    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               s_valid;
    logic               s_ready;
    logic [1:0]         s_label;
    logic               s_train;
    logic               layer_valid;
    logic               layer_learn;
    logic [2:0][7:0]    layer_out;
    logic [2:0][7:0]    expected_out;
    logic               r_valid;
    logic               r_ready;
    logic [1:0]         r_pred;
    logic               r_correct;
    logic               clear_counts;
    logic [CW-1:0]      sample_count;
    logic [CW-1:0]      correct_count;

    classifier3_train_ctrl #(
        .W(8), .SETTLE(S), .LEARN_CYCLES(L), .CNT_W(CW),
        .TARGET_HI(8'hFF), .TARGET_LO(8'h00)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_label(s_label), .s_train(s_train),
        .layer_valid(layer_valid), .layer_learn(layer_learn),
        .layer_out(layer_out), .expected_out(expected_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_pred(r_pred), .r_correct(r_correct),
        .clear_counts(clear_counts),
        .sample_count(sample_count), .correct_count(correct_count)
    );

    always #5 clock = ~clock;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    // reference state
    int unsigned    m_samp = 0;
    int unsigned    m_corr = 0;
    int unsigned    m_pred = 0;
    bit             m_rc   = 0;
    logic [2:0][7:0] m_eo  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_layer_valid", layer_valid, 0);
        chk("rst_layer_learn", layer_learn, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_pred", r_pred, 0);
        chk("rst_r_correct", r_correct, 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_correct_count", correct_count, 0);
        chk("rst_expected_out", expected_out, 0);
    endtask

    // One sample, called just after a rising edge with the DUT idle.
    // The layer outputs are valid only in the capture cycle; everything else
    // the bench drives while busy is noise that must be ignored.
    task automatic run_sample(input logic [1:0] lab, input logic trn,
                              input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                              input int unsigned stall, input bit clr_cap);
        logic [7:0]  v[3];
        int unsigned pred, cap, rs, rend;
        bit          corr, learn;
        v = '{v0, v1, v2};
        pred = 0;
        for (int unsigned i = 1; i < 3; i++) if (v[i] > v[pred]) pred = i;
        corr  = (lab != 2'd3) && (pred == int'(lab));
        learn = trn && (lab != 2'd3);
`ifdef CLASSIFIER3_SKIP_CORRECT_EN
        learn = learn && !corr;
`endif
        cap  = 2 + S;
        rs   = cap + 1 + (learn ? L : 0);
        rend = rs + stall + 1;

        s_valid = 1'b1; s_label = lab; s_train = trn;
        layer_out = 24'($urandom); r_ready = 1'($urandom); clear_counts = 1'b0;
        @(negedge clock);
        chk("accept_s_ready", s_ready, 1);
        for (int unsigned i = 0; i < 3; i++) m_eo[i] = (int'(lab) == i) ? 8'hFF : 8'h00;

        for (int unsigned c = 1; c <= rend; c++) begin
            @(posedge clock); #1;
            s_valid      = (c < rend) ? 1'($urandom) : 1'b0;
            s_label      = 2'($urandom);
            s_train      = 1'($urandom);
            layer_out    = (c == cap) ? {v2, v1, v0} : 24'($urandom);
            r_ready      = (c < rs) ? 1'($urandom) : (c >= rs + stall);
            clear_counts = clr_cap && (c == cap);
            @(negedge clock);
            if (c == cap + 1) begin
                if (clr_cap) begin
                    m_samp = 0; m_corr = 0;
                end else begin
                    if (m_samp < CMAX) m_samp++;
                    if (corr && m_corr < CMAX) m_corr++;
                end
                m_pred = pred; m_rc = corr;
            end
            chk("layer_valid", layer_valid, (c == 1) || (learn && c > cap && c < rs));
            chk("layer_learn", layer_learn, learn && c > cap && c < rs);
            chk("r_valid", r_valid, (c >= rs) && (c < rend));
            chk("s_ready", s_ready, c == rend);
            chk("expected_out", expected_out, m_eo);
            chk("r_pred", r_pred, m_pred);
            chk("r_correct", r_correct, m_rc);
            chk("sample_count", sample_count, m_samp);
            chk("correct_count", correct_count, m_corr);
        end
        @(posedge clock); #1;
        s_valid = 1'b0; clear_counts = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_label = '0; s_train = 1'b0;
        layer_out = '0; r_ready = 1'b0; clear_counts = 1'b0;
        #12;
        chk_reset_vals();
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk_reset_vals();
        @(posedge clock); #1;

        // label 1, train, clear winner
        run_sample(2'd1, 1'b1, 8'd10, 8'd200, 8'd50, 0, 1'b0);
        // tie between classes 0 and 1, label 2, no train
        run_sample(2'd2, 1'b0, 8'd90, 8'd90, 8'd3, 0, 1'b0);
        // unlabelled with train
        run_sample(2'd3, 1'b1, 8'd5, 8'd6, 8'd7, 0, 1'b0);
        // backpressure for 5 cycles
        run_sample(2'd0, 1'b1, 8'd100, 8'd20, 8'd30, 5, 1'b0);
        // misclassified training sample
        run_sample(2'd2, 1'b1, 8'd1, 8'd250, 8'd249, 1, 1'b0);
        // full-scale tie across all three
        run_sample(2'd0, 1'b1, 8'd255, 8'd255, 8'd255, 0, 1'b0);

        // drive counters to saturation with correct samples
        for (int n = 0; n < 18; n++) begin
            logic [7:0] a, b, c;
            logic [1:0] lab;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            lab = (b > a) ? ((c > b) ? 2'd2 : 2'd1) : ((c > a) ? 2'd2 : 2'd0);
            run_sample(lab, 1'($urandom), a, b, c, $urandom_range(0, 2), 1'b0);
        end
        chk("sat_sample_count", sample_count, CMAX);
        chk("sat_correct_count", correct_count, CMAX);

        // clear during capture wins over the increment
        run_sample(2'd1, 1'b0, 8'd0, 8'd9, 8'd1, 0, 1'b1);

        // random samples, narrow value range to provoke ties
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a, b, c;
            if (n % 2 == 0) begin
                a = 8'($urandom_range(0, 3)); b = 8'($urandom_range(0, 3)); c = 8'($urandom_range(0, 3));
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
            run_sample(2'($urandom), 1'($urandom), a, b, c, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
        end

        // reset while learning: label 0 but class 1 wins, so learn runs in either build
        s_valid = 1'b1; s_label = 2'd0; s_train = 1'b1; r_ready = 1'b1;
        for (int unsigned c = 1; c <= 3 + S; c++) begin
            @(posedge clock); #1;
            s_valid = 1'b0;
            layer_out = {8'd0, 8'd50, 8'd0};
        end
        chk("learn_before_reset", layer_learn, 1);
        reset_n = 1'b0;
        #1;
        chk("learn_async_drop", layer_learn, 0);
        chk_reset_vals();
        m_samp = 0; m_corr = 0; m_pred = 0; m_rc = 0; m_eo = '0;
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;

        run_sample(2'd2, 1'b1, 8'd3, 8'd4, 8'd200, 2, 1'b0);
        run_sample(2'd1, 1'b1, 8'd3, 8'd4, 8'd200, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/classifier3_train_ctrl.md
# classifier3_train_ctrl

Sequencing and scoring stage wrapped around the 3-output learning layer. It accepts one labelled sample per valid/ready handshake and drives the layer's `valid`/`learn` strobes. It builds the layer's `expected_out` targets from the label, captures the layer outputs, picks the winning class and keeps running accuracy counters. Results leave through a second valid/ready handshake toward the host/readout logic.

## Interface
- `SETTLE`, default 2: cycles between the evaluate strobe and output capture; must be ≥1.
- `LEARN_CYCLES`, default 1: cycles `layer_learn` is held high per training sample; must be ≥1.
- `CNT_W`, default 16: width of the accuracy counters.
- `TARGET_HI`, default full-scale `zero2one_t`: target for the labelled class.
- `TARGET_LO`, default zero `zero2one_t`: target for the other classes.
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: sample request.
- `s_ready` out 1: controller can accept a sample.
- `s_label` in 2: class index 0..2; 3 means unlabelled.
- `s_train` in 1: run the learn phase for this sample.
- `layer_valid` out 1: to the layer's `valid`.
- `layer_learn` out 1: to the layer's `learn`.
- `layer_out` in `zero2one_t`[3]: layer outputs.
- `expected_out` out `zero2one_t`[3]: layer targets.
- `r_valid` out 1: result available.
- `r_ready` in 1: result consumed.
- `r_pred` out 2: argmax class.
- `r_correct` out 1: `r_pred` equals the label.
- `clear_counts` in 1: synchronous counter clear.
- `sample_count` out `CNT_W`: samples scored.
- `correct_count` out `CNT_W`: correct samples.

## Operation
- State machine: IDLE → EVAL → WAIT → CAPTURE → LEARN (optional) → RESULT → IDLE.
- **IDLE**
  - `s_ready`=1.
  - On `s_valid && s_ready`, latch `s_label` and `s_train`, then go to EVAL.
- **EVAL:** `layer_valid`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** count `SETTLE` cycles with `layer_valid`=0, then go to CAPTURE.
- **CAPTURE** (one cycle):
  - Register the argmax of `layer_out` using unsigned compare; on a tie the lower index wins.
  - Register `r_correct`. It is 1 only if the label ≠3 and the argmax equals the label.
  - Update the counters.
  - Go to LEARN if the latched train bit is set and the label ≠3; otherwise go to RESULT.
- **LEARN:** `layer_valid`=1 and `layer_learn`=1 for `LEARN_CYCLES` consecutive cycles, then go to RESULT.
- **RESULT:** `r_valid`=1 until `r_valid && r_ready`, then go to IDLE.
- **`expected_out`**
  - Registered from the latched label at accept and constant until the next accept.
  - Entry [label] = `TARGET_HI`, all other entries = `TARGET_LO`.
  - Label 3 gives all `TARGET_LO`.
- **Counters**
  - `sample_count` increments in every CAPTURE.
  - `correct_count` increments when `r_correct`.
  - Both saturate at all-ones.
  - `clear_counts` zeroes both and has priority over a same-cycle increment; that increment is lost.
- `r_pred` and `r_correct` hold from CAPTURE until the next CAPTURE.

## Timing
- Reset values:
  - State IDLE.
  - `s_ready`=1.
  - `layer_valid`=0, `layer_learn`=0.
  - `r_valid`=0, `r_pred`=0, `r_correct`=0.
  - Both counters 0.
  - `expected_out` all `TARGET_LO`.
- Accept at cycle 0:
  - EVAL in cycle 1.
  - CAPTURE in cycle 2+`SETTLE`.
  - `r_valid` first high in cycle 3+`SETTLE` without learn, or 3+`SETTLE`+`LEARN_CYCLES` with learn.
- Throughput is one sample in flight. `s_ready` drops the cycle after accept and returns the cycle after the result handshake.
- `r_ready` held high gives a one-cycle RESULT. Backpressure stalls in RESULT with all outputs stable.
- `s_valid` outside IDLE is ignored; the sample is not consumed.
- Reset asserted mid-operation aborts immediately to the reset values. `layer_learn` falls asynchronously.

## Configuration
- `CLASSIFIER3_SKIP_CORRECT_EN`
  - Defined: LEARN is skipped when `r_correct`=1, even if the train bit is set. Only misclassified, labelled samples train.
  - Undefined: every labelled training sample runs LEARN.

## Test plan
- Reset, then idle: all outputs at their reset values and `s_ready`=1.
- Label 1, train, `layer_out`={10,200,50}, `SETTLE`=2:
  - `layer_valid` pulses in cycle 1.
  - `expected_out`={LO,HI,LO}.
  - `layer_learn` is high for 1 cycle in cycle 5.
  - `r_valid` rises in cycle 6 with `r_pred`=1 and `r_correct`=1; counts 1/1.
- Tie `layer_out`={90,90,3`}, label 2, no train:
  - `r_pred`=0, `r_correct`=0, no `layer_learn`.
  - `sample_count`+1, `correct_count` unchanged.
- Label 3 with train: no LEARN; `expected_out` all LO; `r_correct`=0.
- Backpressure:
  - Hold `r_ready`=0 for 5 cycles: `r_valid` and `r_pred` stay stable and `s_ready`=0.
  - Then `r_ready`=1: `s_ready`=1 in the next cycle.
- Boundary and reset cases:
  - Preload counters to all-ones: they saturate.
  - `clear_counts` during CAPTURE: both counters read 0.
  - `reset_n` low during LEARN: `layer_learn` drops immediately.
  - With `CLASSIFIER3_SKIP_CORRECT_EN`, a correct training sample shows no `layer_learn`.
